keycode_joypad: RTL and testbench
=================================

KEYCODE_JOYPAD -- requirements
Module: keycode_joypad

Interface
REQ-001 SHALL have parameter OPEN_BUS_HI, default 8'h40; it supplies bits [7:1] of every read.
REQ-002 SHALL have port Clk  in  1  CPU clock (the same clock as the controller bus).
REQ-003 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port keycode0  in  8  USB HID keycode slot 0 (8'h00 = no key).
REQ-005 SHALL have port keycode1  in  8  USB HID keycode slot 1 (8'h00 = no key).
REQ-006 SHALL have port cs_n  in  1  active-low chip select from the address decoder.
REQ-007 SHALL have port addr  in  1  register select: 0 = $4016, 1 = $4017.
REQ-008 SHALL have port rw  in  1  bus direction: 1 = read, 0 = write.
REQ-009 SHALL have port data_in  in  8  CPU write data.
REQ-010 SHALL have port data_out  out  8  CPU read data.
REQ-011 SHALL have port data_oe  out  1  bus drive enable; 1 only during a selected read.
REQ-012 SHALL have port buttons  out  8  registered P1 live button vector, for debug and hex display.

Function
REQ-013 Button bit order SHALL be: 0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right.
REQ-014 P1 key map SHALL be: 8'h0E→A, 8'h0D→B, 8'h2C→Select, 8'h28→Start, 8'h1A→Up, 8'h16→Down, 8'h04→Left, 8'h07→Right; all other codes map to no button.
REQ-015 live1 SHALL equal map(keycode0) | map(keycode1), registered each Clk (1-cycle latency); buttons = live1; a duplicate keycode in both slots is harmless.
REQ-016 A write (cs_n=0, rw=0, addr=0) SHALL set strobe <= data_in[0]; writes with addr=1 SHALL be ignored.
REQ-017 While strobe=1, shift1 SHALL reload from live1 every cycle, and reads SHALL return live1[0] without shifting.
REQ-018 When strobe falls 1→0, shift1 SHALL hold the last value loaded.
REQ-019 A read (cs_n=0, rw=1, addr=0) with strobe=0 SHALL present shift1[0] that cycle; at the clock edge shift1 <= {1'b1, shift1[7:1]}, exactly one shift per selected read cycle.
REQ-020 After 8 shifts, every further read SHALL return 1 until the next reload.
REQ-021 During a selected read, data_out SHALL equal {OPEN_BUS_HI[7:1], bit}; otherwise data_out = 8'h00. data_oe SHALL equal ~cs_n & rw.
REQ-022 A read with addr=1 SHALL return {OPEN_BUS_HI[7:1], 1'b0} when P2 is compiled out (see REQ-027).
REQ-023 Read and write cannot occur in the same cycle, and the block SHALL not arbitrate them; a strobe write always takes priority over the shift state.

Reset
REQ-024 When Reset=1 at a Clk edge: strobe=0, live1=0, shift1=8'h00, and the P2 state likewise 0.
REQ-025 Reset SHALL abort any read sequence in progress; afterwards reads return 0 for 8 reads, then 1.
REQ-026 Outputs during and after reset SHALL be: data_oe follows cs_n/rw combinationally; buttons=8'h00.

Configuration
REQ-027 Macro JOYPAD_P2_EN SHALL select player 2.
- Defined: live2/shift2 SHALL be built with map 8'h37→A, 8'h36→B, 8'h2F→Select, 8'h30→Start, 8'h52→Up, 8'h51→Down, 8'h50→Left, 8'h4F→Right. The same strobe from $4016 SHALL drive both players. Reads at addr=1 SHALL follow REQ-017..020 using shift2.
- Undefined: no P2 state is built, and REQ-022 applies.

Verification
REQ-028 keycode0=8'h0E, keycode1=8'h28; write $4016=1 then 0; 9 reads → 41,40,40,41,40,40,40,40,41.
REQ-029 Strobe held 1; keycode0 changes 00→0E; reads → 40 until 2 cycles after the change, then 41, with no shifting.
REQ-030 Both keycodes 00, strobe pulse, 10 reads → eight 40, then 41,41.
REQ-031 After the strobe pulse with A pressed, do 3 reads, then pulse Reset; 9 reads → eight 40, then 41.
REQ-032 $4017 read, macro off → 40 with data_oe=1. Macro on: keycode0=8'h52, strobe pulse; reads 1..5 at $4017 → 40,40,40,40,41.
REQ-033 Idle bus (cs_n=1) → data_out=00 and data_oe=0 regardless of keycodes.

Source files
------------

// File: rtl/keycode_joypad.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : keycode_joypad                                                 |
// | Purpose  : NES $4016/$4017 joypad built from two USB HID keycode slots.   |
// |            Define JOYPAD_P2_EN to build the player-2 pad on $4017.        |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
module keycode_joypad #(
   parameter logic [7:0] OPEN_BUS_HI = 8'h40
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [7:0] keycode0,
   input  logic [7:0] keycode1,
   input  logic       cs_n,
   input  logic       addr,
   input  logic       rw,
   input  logic [7:0] data_in,
   output logic [7:0] data_out,
   output logic       data_oe,
   output logic [7:0] buttons
);

   localparam logic [6:0] c_OPEN_HI = OPEN_BUS_HI[7:1];

   // Button order: A, B, Select, Start, Up, Down, Left, Right (bit 0..7)
   function automatic logic [7:0] map_p1(input logic [7:0] code);
      logic [7:0] btn;
      btn = 8'h00;
      case (code)
         8'h0E:   btn = 8'h01;
         8'h0D:   btn = 8'h02;
         8'h2C:   btn = 8'h04;
         8'h28:   btn = 8'h08;
         8'h1A:   btn = 8'h10;
         8'h16:   btn = 8'h20;
         8'h04:   btn = 8'h40;
         8'h07:   btn = 8'h80;
         default: btn = 8'h00;
      endcase
      return btn;
   endfunction

   logic       r_strobe;
   logic [7:0] r_live1;
   logic [7:0] r_shift1;
   logic       w_rd;
   logic       w_rd0;
   logic       w_rd1;
   logic       w_wr0;
   logic       w_bit0;
   logic       w_bit1;
   logic       w_unused;

   assign w_rd     = ~cs_n & rw;
   assign w_rd0    = w_rd & ~addr;
   assign w_rd1    = w_rd & addr;
   assign w_wr0    = ~cs_n & ~rw & ~addr;
   assign w_unused = &{1'b0, data_in[7:1]};

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_strobe <= 1'b0;
         r_live1  <= 8'h00;
         r_shift1 <= 8'h00;
      end else begin
         r_live1 <= map_p1(keycode0) | map_p1(keycode1);
         if (w_wr0)
            r_strobe <= data_in[0];
         // Shift fills with 1s so reads past the 8th button return 1
         if (r_strobe)
            r_shift1 <= r_live1;
         else if (w_rd0)
            r_shift1 <= {1'b1, r_shift1[7:1]};
      end
   end

   assign w_bit0 = r_strobe ? r_live1[0] : r_shift1[0];

`ifdef JOYPAD_P2_EN
   function automatic logic [7:0] map_p2(input logic [7:0] code);
      logic [7:0] btn;
      btn = 8'h00;
      case (code)
         8'h37:   btn = 8'h01;
         8'h36:   btn = 8'h02;
         8'h2F:   btn = 8'h04;
         8'h30:   btn = 8'h08;
         8'h52:   btn = 8'h10;
         8'h51:   btn = 8'h20;
         8'h50:   btn = 8'h40;
         8'h4F:   btn = 8'h80;
         default: btn = 8'h00;
      endcase
      return btn;
   endfunction

   logic [7:0] r_live2;
   logic [7:0] r_shift2;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_live2  <= 8'h00;
         r_shift2 <= 8'h00;
      end else begin
         r_live2 <= map_p2(keycode0) | map_p2(keycode1);
         if (r_strobe)
            r_shift2 <= r_live2;
         else if (w_rd1)
            r_shift2 <= {1'b1, r_shift2[7:1]};
      end
   end

   assign w_bit1 = r_strobe ? r_live2[0] : r_shift2[0];
`else
   assign w_bit1 = 1'b0 & w_rd1;
`endif

   assign data_oe  = w_rd;
   assign data_out = w_rd ? {c_OPEN_HI, (addr ? w_bit1 : w_bit0)} : 8'h00;
   assign buttons  = r_live1;

endmodule
`default_nettype wire

// File: tb/tb_keycode_joypad.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_keycode_joypad                                              |
// | Purpose  : Directed self-checking bench for keycode_joypad.               |
// | Revision : 1.0  initial release                                           |
// +---------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_keycode_joypad;

   logic       clk;
   logic       rst;
   logic [7:0] keycode0;
   logic [7:0] keycode1;
   logic       cs_n;
   logic       addr;
   logic       rw;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       data_oe;
   logic [7:0] buttons;

   int n_checks = 0;
   int n_errors = 0;

   keycode_joypad #(.OPEN_BUS_HI(8'h40)) dut (
      .Clk      (clk),
      .Reset    (rst),
      .keycode0 (keycode0),
      .keycode1 (keycode1),
      .cs_n     (cs_n),
      .addr     (addr),
      .rw       (rw),
      .data_in  (data_in),
      .data_out (data_out),
      .data_oe  (data_oe),
      .buttons  (buttons)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic a, input logic [7:0] d);
      @(negedge clk);
      cs_n = 1'b0; rw = 1'b0; addr = a; data_in = d;
      @(posedge clk); #1;
      cs_n = 1'b1; rw = 1'b1; data_in = 8'h00;
   endtask

   task automatic bus_read(input logic a, input logic [7:0] exp, input string tag);
      @(negedge clk);
      cs_n = 1'b0; rw = 1'b1; addr = a;
      #1;
      check_val(tag, data_out, exp);
      check_val({tag, "_oe"}, {7'd0, data_oe}, 8'h01);
      @(posedge clk); #1;
      cs_n = 1'b1;
   endtask

   task automatic strobe_pulse();
      bus_write(1'b0, 8'h01);
      bus_write(1'b0, 8'h00);
   endtask

   task automatic read_seq(input logic a, input logic [7:0] exp[$], input string tag);
      foreach (exp[i])
         bus_read(a, exp[i], $sformatf("%s_%0d", tag, i));
   endtask

   initial begin
      rst = 1'b1; keycode0 = 8'h00; keycode1 = 8'h00;
      cs_n = 1'b1; addr = 1'b0; rw = 1'b1; data_in = 8'h00;
      idle_cycles(3);

      // Reset state; data_oe stays combinational during reset
      check_val("rst_buttons", buttons, 8'h00);
      check_val("rst_dout", data_out, 8'h00);
      check_val("rst_oe_idle", {7'd0, data_oe}, 8'h00);
      @(negedge clk); cs_n = 1'b0; #1;
      check_val("rst_oe_read", {7'd0, data_oe}, 8'h01);
      cs_n = 1'b1;
      @(negedge clk); rst = 1'b0;

      // Idle bus with keys pressed
      keycode0 = 8'h0E; keycode1 = 8'h28;
      idle_cycles(2);
      check_val("idle_dout", data_out, 8'h00);
      check_val("idle_oe", {7'd0, data_oe}, 8'h00);
      check_val("btn_a_start", buttons, 8'h09);

      // A + Start, strobe pulse, $4017 write must not disturb the strobe
      strobe_pulse();
      bus_write(1'b1, 8'h01);
      read_seq(1'b0, '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41}, "seq_as");

      // Duplicate keycodes, unmapped codes
      keycode0 = 8'h0E; keycode1 = 8'h0E;
      idle_cycles(2);
      check_val("btn_dup", buttons, 8'h01);
      keycode0 = 8'h05; keycode1 = 8'h07;
      idle_cycles(2);
      check_val("btn_right", buttons, 8'h80);
      keycode0 = 8'h2C; keycode1 = 8'h1A;
      idle_cycles(2);
      check_val("btn_sel_up", buttons, 8'h14);

      // Strobe held high while the key appears
      keycode0 = 8'h00; keycode1 = 8'h00;
      idle_cycles(2);
      bus_write(1'b0, 8'h01);
      @(negedge clk);
      keycode0 = 8'h0E; cs_n = 1'b0; rw = 1'b1; addr = 1'b0;
      #1;
      check_val("strb_same", data_out, 8'h40);
      @(negedge clk); @(negedge clk); #1;
      check_val("strb_2cyc", data_out, 8'h41);
      @(negedge clk); #1;
      check_val("strb_hold", data_out, 8'h41);
      @(posedge clk); #1;
      cs_n = 1'b1;
      bus_write(1'b0, 8'h00);
      read_seq(1'b0, '{8'h41, 8'h40, 8'h40}, "strb_fall");

      // No keys: eight 0s then 1s
      keycode0 = 8'h00;
      idle_cycles(2);
      strobe_pulse();
      read_seq(1'b0, '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41}, "nokey");

      // Reset mid-sequence
      keycode0 = 8'h0E;
      idle_cycles(2);
      strobe_pulse();
      read_seq(1'b0, '{8'h41, 8'h40, 8'h40}, "pre_rst");
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      check_val("rst_mid_btn", buttons, 8'h00);
      @(negedge clk); rst = 1'b0;
      read_seq(1'b0, '{8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41}, "post_rst");

`ifdef JOYPAD_P2_EN
      keycode0 = 8'h52; keycode1 = 8'h00;
      idle_cycles(2);
      strobe_pulse();
      read_seq(1'b1, '{8'h40, 8'h40, 8'h40, 8'h40, 8'h41}, "p2_up");
`else
      bus_read(1'b1, 8'h40, "p2_off");
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
